hazard_ctrl: RTL

- Pipeline hazard and sequencing controller for the 5-stage datapath (IF, ID, EX, MEM, WB).
- Generates the ALU operand forwarding selects consumed by the EX stage.
- Generates load-use stalls, branch-taken flushes (branch resolves in MEM from registered Branch/zero) and whole-pipeline freeze on a memory busy handshake.
- Keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 30 +++
 rtl/hazard_ctrl_if.sv | 56 +++++
 rtl/hazard_ctrl_forward_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef logic [1:0] fwd_sel_t;
  typedef logic [4:0] reg_idx_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;

  localparam reg_idx_t REG_ZERO = 5'd0;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_LSTALL = 1'b1;

  // Operand select for one EX source register; the younger EX/MEM result wins.
  function automatic fwd_sel_t fwd_select(input reg_idx_t src,
                                          input logic     exmem_we,
                                          input reg_idx_t exmem_dst,
                                          input logic     memwb_we,
                                          input reg_idx_t memwb_dst);
    if (exmem_we && (exmem_dst != REG_ZERO) && (exmem_dst == src))
      return FWD_EXMEM;
    else if (memwb_we && (memwb_dst != REG_ZERO) && (memwb_dst == src))
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  reg_idx_t         id_rs;
  reg_idx_t         id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  reg_idx_t         idex_rs;
  reg_idx_t         idex_rt;
  reg_idx_t         idex_reg_dest;
  logic             idex_MemRead;
  reg_idx_t         exmem_reg_dest;
  logic             exmem_RegWrite;
  logic             exmem_Branch;
  logic             exmem_zero;
  reg_idx_t         memwb_reg_dest;
  logic             memwb_RegWrite;
  logic             mem_busy;

  fwd_sel_t         forward_a;
  fwd_sel_t         forward_b;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             if_id_flush;
  logic             ex_mem_flush;
  logic             id_ex_bubble;
  logic             pc_src_branch;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, idex_rs, idex_rt,
           idex_reg_dest, idex_MemRead, exmem_reg_dest, exmem_RegWrite,
           exmem_Branch, exmem_zero, memwb_reg_dest, memwb_RegWrite, mem_busy,
    input  forward_a, forward_b, pc_write, if_id_write, id_ex_write,
           ex_mem_write, mem_wb_write, if_id_flush, ex_mem_flush,
           id_ex_bubble, pc_src_branch, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, idex_rs, idex_rt,
           idex_reg_dest, idex_MemRead, exmem_reg_dest, exmem_RegWrite,
           exmem_Branch, exmem_zero, memwb_reg_dest, memwb_RegWrite, mem_busy,
    output forward_a, forward_b, pc_write, if_id_write, id_ex_write,
           ex_mem_write, mem_wb_write, if_id_flush, ex_mem_flush,
           id_ex_bubble, pc_src_branch, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// ALU operand forwarding selects for both EX source operands.
module hazard_ctrl_forward_unit
  import hazard_ctrl_pkg::*;
(
  input  reg_idx_t idex_rs,
  input  reg_idx_t idex_rt,
  input  reg_idx_t exmem_reg_dest,
  input  logic     exmem_RegWrite,
  input  reg_idx_t memwb_reg_dest,
  input  logic     memwb_RegWrite,
  output fwd_sel_t forward_a,
  output fwd_sel_t forward_b
);

  // Same priority rule applied independently to rs and rt.
  always_comb begin
    forward_a = fwd_select(idex_rs, exmem_RegWrite, exmem_reg_dest,
                           memwb_RegWrite, memwb_reg_dest);
    forward_b = fwd_select(idex_rt, exmem_RegWrite, exmem_reg_dest,
                           memwb_RegWrite, memwb_reg_dest);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: forwarding, load-use stalls,
// branch flushes, memory-busy freeze and saturating perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input logic       clock,
  input logic       reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  logic [0:0]       state;
  logic [2:0]       stall_left;
  logic             rst_q;
  logic             force_rst;
  logic             hazard;
  logic             taken;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;

  hazard_ctrl_forward_unit forward_unit (
    .idex_rs        (bus.idex_rs),
    .idex_rt        (bus.idex_rt),
    .exmem_reg_dest (bus.exmem_reg_dest),
    .exmem_RegWrite (bus.exmem_RegWrite),
    .memwb_reg_dest (bus.memwb_reg_dest),
    .memwb_RegWrite (bus.memwb_RegWrite),
    .forward_a      (fwd_a),
    .forward_b      (fwd_b)
  );

  // Reset stays in force for one extra cycle after reset drops (rst_q).
  assign force_rst = reset | rst_q;

  assign hazard = bus.idex_MemRead && (bus.idex_reg_dest != REG_ZERO) &&
                  ((bus.id_uses_rs && (bus.idex_reg_dest == bus.id_rs)) ||
                   (bus.id_uses_rt && (bus.idex_reg_dest == bus.id_rt)));
  assign taken  = bus.exmem_Branch && bus.exmem_zero;

  assign bus.forward_a   = force_rst ? FWD_RF : fwd_a;
  assign bus.forward_b   = force_rst ? FWD_RF : fwd_b;
  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;

  // FSM, stall down-counter and counters; priority reset > busy > taken > stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      rst_q      <= 1'b1;
      state      <= ST_RUN;
      stall_left <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      rst_q <= 1'b0;
      if (rst_q) begin
        state      <= ST_RUN;
        stall_left <= '0;
        stall_cnt  <= '0;
        flush_cnt  <= '0;
      end else if (bus.mem_busy) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end else if (taken) begin
        state      <= ST_RUN;
        stall_left <= '0;
        if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end else if (state == ST_LSTALL) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        stall_left <= stall_left - 3'd1;
        if (stall_left <= 3'd1) state <= ST_RUN;
      end else if (hazard) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          state      <= ST_LSTALL;
          stall_left <= STALL_RELOAD;
        end
      end
    end
  end

  // Stage enables, flushes and PC select from the same priority order.
  always_comb begin
    bus.pc_write      = 1'b1;
    bus.if_id_write   = 1'b1;
    bus.id_ex_write   = 1'b1;
    bus.ex_mem_write  = 1'b1;
    bus.mem_wb_write  = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_bubble  = 1'b0;
    bus.ex_mem_flush  = 1'b0;
    bus.pc_src_branch = 1'b0;
    if (force_rst || bus.mem_busy) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_write  = 1'b0;
      bus.ex_mem_write = 1'b0;
      bus.mem_wb_write = 1'b0;
      if (force_rst) begin
        bus.if_id_flush  = 1'b1;
        bus.id_ex_bubble = 1'b1;
        bus.ex_mem_flush = 1'b1;
      end
    end else if (taken) begin
      bus.pc_src_branch = 1'b1;
      bus.if_id_flush   = 1'b1;
      bus.id_ex_bubble  = 1'b1;
      bus.ex_mem_flush  = 1'b1;
    end else if ((state == ST_LSTALL) || hazard) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_bubble = 1'b1;
    end
  end

endmodule
